mem_io_resp: RTL
================

MEM_IO_RESP -- requirements
Module: mem_io_resp

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 17, giving 128 KB byte RAM.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of two), setting depth of the RX and TX byte FIFOs.
REQ-003 SHALL have one clock and an asynchronous active-high reset: clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port mem_a  input  32  CPU byte address; only [17:0] decoded.
REQ-006 SHALL have port mem_wr  input  1  1 = write this cycle, 0 = read.
REQ-007 SHALL have port mem_dout  input  8  CPU write data.
REQ-008 SHALL have port mem_din  output  8  read data to CPU.
REQ-009 SHALL have port cpu_rdy  output  1  CPU may proceed; low pauses CPU.
REQ-010 SHALL have ports rx_valid/rx_data/rx_ready  input 1/input 8/output 1  host-to-CPU byte stream.
REQ-011 SHALL have ports tx_valid/tx_data/tx_ready  output 1/output 8/input 1  CPU-to-host byte stream.
REQ-012 SHALL have port halted  output  1  sticky program-stop flag.

Function
REQ-013 SHALL decode mem_a[17:16]==2'b11 as IO space, mem_a < 0x20000 as RAM, and all else as a hole.
REQ-014 SHALL treat every clock with cpu_rdy high as one access; the CPU never parks on an IO address while idle.
REQ-015 SHALL register reads: address in cycle N -> mem_din valid throughout cycle N+1, held until the next read.
REQ-016 SHALL complete writes at the rising edge ending the cycle; read-after-write to the same address returns the new byte.
REQ-017 SHALL make RAM reads return mem[mem_a[16:0]] and RAM writes update that byte.
REQ-018 SHALL make hole reads return 0x00 and ignore hole writes.
REQ-019 SHALL make a read of 0x30000 pop the RX FIFO head and return it next cycle; reading an empty FIFO returns 0x00 and pops nothing.
REQ-020 SHALL make a write of 0x30000 push mem_dout into the TX FIFO unless the byte is 0x00; a push to a full FIFO drops the byte and sets internal overflow.
REQ-021 SHALL keep a 32-bit cycle counter: 0 after reset, +1 every clock, wrapping 0xFFFFFFFF->0.
REQ-022 SHALL make a read of 0x30004 snapshot the counter and return byte 0; reads of 0x30005..0x30007 return snapshot bytes 1..3.
REQ-023 SHALL make a write of 0x30004 set halted, push 0x00 into TX (bypassing the zero filter), and ignore all later writes except RAM.
REQ-024 SHALL make reads of other IO addresses return 0x00 and ignore writes to them.
REQ-025 SHALL drive cpu_rdy = (TX occupancy <= FIFO_DEPTH-2), so one in-flight write always fits.
REQ-026 SHALL set rx_ready = RX not full; a push occurs on rx_valid&&rx_ready, and a simultaneous push and pop both take effect.
REQ-027 SHALL set tx_valid = TX not empty with tx_data = head, popping on tx_valid&&tx_ready; a simultaneous push and pop keeps occupancy.
REQ-028 SHALL use FIFO pointers of log2(FIFO_DEPTH)+1 bits, with full/empty derived from the MSB compare, correct across wrap.

Reset
REQ-029 SHALL on reset clear mem_din=0x00, both FIFOs empty, counter=0, snapshot=0, halted=0, overflow=0; outputs become rx_ready=1, tx_valid=0, cpu_rdy=1.
REQ-030 SHALL leave RAM contents unaffected by reset; reset mid-access discards the pending read result and any FIFO entries.

Structure
REQ-031 SHALL place IO address constants (0x30000, 0x30004) and the region-decode width in define.v, shared with the CPU memory controller.
REQ-032 SHALL instantiate sub-module fifo_byte (parameterised depth, valid/ready both sides, count output) twice, for RX and TX.
REQ-033 SHALL hold RAM as a single byte array with a registered read port.

Verification
REQ-034 SHALL cover: write 0xA5 @0x00010, read 0x00010 next cycle -> mem_din=0xA5 in the following cycle.
REQ-035 SHALL cover: host pushes 0x41,0x42; CPU reads 0x30000 three times -> 0x41, 0x42, 0x00; rx_ready stays 1.
REQ-036 SHALL cover: write 0x48, 0x00, 0x49 @0x30000 with tx_ready=1 -> tx emits 0x48, 0x49 only.
REQ-037 SHALL cover: tx_ready=0 with 7 writes @0x30000 -> cpu_rdy falls after the 7th push (occupancy 7), no byte lost.
REQ-038 SHALL cover: after 100 clocks read 0x30004..0x30007 -> bytes of the snapshot taken at the 0x30004 read, equal across all four reads.
REQ-039 SHALL cover: write @0x30004 -> halted=1 sticky, TX emits 0x00; a later write 0x55 @0x30000 produces no TX output.

Source files
------------

// File: rtl/mem_io_resp_pkg.sv
// mem_io_resp_pkg: address map shared between the CPU memory controller and
// the memory/IO responder.
//   - DECODE_W        : number of low CPU address bits that take part in decode
//   - IO_*_ADDR       : memory-mapped IO registers
//   - region_t        : result of the address decode
//   - decode_region() : RAM / IO / hole classification of a decoded address
package mem_io_resp_pkg;

    localparam int DECODE_W = 18;

    localparam logic [DECODE_W-1:0] IO_RXTX_ADDR  = 18'h30000;
    localparam logic [DECODE_W-1:0] IO_CYCLE_ADDR = 18'h30004;
    localparam logic [DECODE_W-1:0] IO_SNAP1_ADDR = 18'h30005;
    localparam logic [DECODE_W-1:0] IO_SNAP2_ADDR = 18'h30006;
    localparam logic [DECODE_W-1:0] IO_SNAP3_ADDR = 18'h30007;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_IO   = 2'd1,
        REGION_HOLE = 2'd2
    } region_t;

    // IO occupies 0x30000-0x3FFFF; everything below 0x20000 is RAM;
    // 0x20000-0x2FFFF is unmapped.
    function automatic region_t decode_region(input logic [DECODE_W-1:0] addr);
        region_t region;
        if (addr[17:16] == 2'b11) begin
            region = REGION_IO;
        end else if (addr[17] == 1'b0) begin
            region = REGION_RAM;
        end else begin
            region = REGION_HOLE;
        end
        return region;
    endfunction

endpackage

// File: rtl/mem_io_resp_fifo_byte.sv
// fifo_byte: byte-wide synchronous FIFO with valid/ready on both sides.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   in_valid/in_data      : write side; a push happens on in_valid && in_ready
//   in_ready              : FIFO not full
//   out_valid/out_data    : read side; out_data is the current head
//   out_ready             : a pop happens on out_valid && out_ready
//   count                 : current occupancy (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_byte #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  store [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign out_data  = store[rd_ptr_r[AW-1:0]];
    assign count     = wr_ptr_r - rd_ptr_r;
    assign push_s    = in_valid && !full_s;
    assign pop_s     = !empty_s && out_ready;

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (push_s) begin
            store[wr_ptr_r[AW-1:0]] <= in_data;
        end
    end

    // Read/write pointers; push and pop in the same cycle both advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_io_resp.sv
// mem_io_resp: byte RAM plus memory-mapped IO responder for a simple CPU.
// Ports:
//   clock, reset                : rising-edge clock, async active-high reset
//   mem_a/mem_wr/mem_dout       : CPU access (one per clock while cpu_rdy=1)
//   mem_din                     : registered read data, valid the cycle after
//                                 the read and held until the next read
//   cpu_rdy                     : low stalls the CPU while TX is nearly full
//   rx_valid/rx_data/rx_ready   : host-to-CPU byte stream (RX FIFO input)
//   tx_valid/tx_data/tx_ready   : CPU-to-host byte stream (TX FIFO output)
//   halted                      : sticky stop flag set by a write to 0x30004
// IO map: 0x30000 RX pop (read) / TX push (write, 0x00 filtered);
//         0x30004 cycle-counter snapshot byte 0 (read) / halt (write);
//         0x30005..0x30007 snapshot bytes 1..3.
module mem_io_resp
    import mem_io_resp_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        cpu_rdy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] RDY_LIMIT = CW'(FIFO_DEPTH - 2);

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            ram_q_r;
    logic [7:0]            io_q_r;
    logic                  sel_ram_r;
    logic [31:0]           cycle_r;
    logic [31:0]           snap_r;
    logic                  halted_r;
    logic                  overflow_r;

    logic [DECODE_W-1:0]   addr_s;
    region_t               region_s;
    logic                  rd_s;
    logic                  wr_s;
    logic                  rx_pop_s;
    logic                  rx_out_valid_s;
    logic [7:0]            rx_out_data_s;
    logic [CW-1:0]         rx_count_s;
    logic                  tx_push_s;
    logic [7:0]            tx_push_data_s;
    logic                  tx_in_ready_s;
    logic [CW-1:0]         tx_count_s;
    logic                  halt_set_s;
    logic                  tx_drop_s;
    logic [7:0]            io_rdata_s;
    logic                  unused_s;

    assign addr_s   = mem_a[DECODE_W-1:0];
    assign region_s = decode_region(addr_s);
    assign cpu_rdy  = (tx_count_s <= RDY_LIMIT);
    assign rd_s     = cpu_rdy && !mem_wr;
    assign wr_s     = cpu_rdy && mem_wr;
    assign rx_pop_s = rd_s && (region_s == REGION_IO) &&
                      (addr_s == IO_RXTX_ADDR) && rx_out_valid_s;
    assign tx_drop_s = tx_push_s && !tx_in_ready_s;
    assign mem_din  = sel_ram_r ? ram_q_r : io_q_r;
    assign halted   = halted_r;
    assign unused_s = ^{mem_a[31:DECODE_W], rx_count_s, overflow_r};

    fifo_byte #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rx_valid),
        .in_data   (rx_data),
        .in_ready  (rx_ready),
        .out_valid (rx_out_valid_s),
        .out_data  (rx_out_data_s),
        .out_ready (rx_pop_s),
        .count     (rx_count_s)
    );

    fifo_byte #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (tx_push_s),
        .in_data   (tx_push_data_s),
        .in_ready  (tx_in_ready_s),
        .out_valid (tx_valid),
        .out_data  (tx_data),
        .out_ready (tx_ready),
        .count     (tx_count_s)
    );

    // IO write decode: TX push with zero filter, or halt (which pushes 0x00
    // as the end-of-program marker). Once halted, IO writes are ignored.
    always_comb begin
        tx_push_s      = 1'b0;
        tx_push_data_s = 8'h00;
        halt_set_s     = 1'b0;
        if (wr_s && (region_s == REGION_IO) && !halted_r) begin
            if (addr_s == IO_RXTX_ADDR) begin
                tx_push_s      = (mem_dout != 8'h00);
                tx_push_data_s = mem_dout;
            end else if (addr_s == IO_CYCLE_ADDR) begin
                tx_push_s      = 1'b1;
                tx_push_data_s = 8'h00;
                halt_set_s     = 1'b1;
            end else begin
                tx_push_s      = 1'b0;
            end
        end else begin
            tx_push_s = 1'b0;
        end
    end

    // IO read data; byte 0 of the counter comes live, the same value the
    // snapshot captures, so all four bytes describe one instant.
    always_comb begin
        io_rdata_s = 8'h00;
        case (addr_s)
            IO_RXTX_ADDR:  io_rdata_s = rx_out_valid_s ? rx_out_data_s : 8'h00;
            IO_CYCLE_ADDR: io_rdata_s = cycle_r[7:0];
            IO_SNAP1_ADDR: io_rdata_s = snap_r[15:8];
            IO_SNAP2_ADDR: io_rdata_s = snap_r[23:16];
            IO_SNAP3_ADDR: io_rdata_s = snap_r[31:24];
            default:       io_rdata_s = 8'h00;
        endcase
    end

    // RAM array with a registered read port; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_s && (region_s == REGION_RAM)) begin
            ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
        end
        if (rd_s && (region_s == REGION_RAM)) begin
            ram_q_r <= ram[mem_a[RAM_ADDR_W-1:0]];
        end
    end

    // Read-result registers, cycle counter, snapshot and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_q_r     <= 8'h00;
            sel_ram_r  <= 1'b0;
            cycle_r    <= 32'h0000_0000;
            snap_r     <= 32'h0000_0000;
            halted_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            cycle_r    <= cycle_r + 32'd1;
            overflow_r <= overflow_r | tx_drop_s;
            if (halt_set_s) begin
                halted_r <= 1'b1;
            end
            if (rd_s) begin
                case (region_s)
                    REGION_RAM: begin
                        sel_ram_r <= 1'b1;
                    end
                    REGION_IO: begin
                        sel_ram_r <= 1'b0;
                        io_q_r    <= io_rdata_s;
                        if (addr_s == IO_CYCLE_ADDR) begin
                            snap_r <= cycle_r;
                        end
                    end
                    default: begin
                        sel_ram_r <= 1'b0;
                        io_q_r    <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule
